// File: rtl/debug_pll_pkg.sv
// Shared constants and helpers for the debug-path PLL model: legal parameter
// ranges, supported feedback selections and a constant-foldable clog2.
package debug_pll_pkg;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int DIV_MIN  = 1;
    localparam int DIV_MAX  = 128;
    localparam int LOCK_MIN = 2;
    localparam int LOCK_MAX = 4096;

    localparam FB_CLKOUTF = "CLKOUTF";
    localparam FB_DISABLE = "DISABLE";

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/pll_lock_detect.sv
// Lock detector: checks that the complement reference leg is low on each
// rising edge, counts consecutive good cycles and raises a sticky lock.
module pll_lock_detect
    import debug_pll_pkg::*;
#(
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clkn_i,
    output logic lock_o
);
    timeunit 1ns;
    timeprecision 100ps;

    localparam int CNT_W = clog2(LOCK_CYCLES) + 1;

    logic             clkn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;

    // The registered sample resets to 0 so the first edge after release counts as good.
    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        if (!clkn_q) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q >= CNT_W'(LOCK_CYCLES - 1)) lock_d = 1'b1;
        end else if (!lock_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkn_q <= 1'b0;
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            clkn_q <= clkn_i;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign lock_o = lock_q;
endmodule

// File: rtl/debug_pll.sv
// Digital model of the debug-path PLL: lock detection on the differential
// reference plus an integer divider whose output is gated glitch-free by lock.
module debug_pll
    import debug_pll_pkg::*;
#(
    parameter real CLKIN_FREQ  = 100.0,
    parameter int  CLKOUT0_DIV = 1,
    parameter int  LOCK_CYCLES = 1024,
    parameter      INTERNAL_FB = "CLKOUTF",
    parameter      EXTERNAL_FB = "DISABLE"
) (
    input  logic clkin1_p,
    input  logic rst_n,
    input  logic clkin1_n,
    output logic clkout0,
    output logic lock
);
    timeunit 1ns;
    timeprecision 100ps;

    if (CLKOUT0_DIV < DIV_MIN || CLKOUT0_DIV > DIV_MAX) begin : g_bad_div
        $error("debug_pll: CLKOUT0_DIV out of range");
    end
    if (LOCK_CYCLES < LOCK_MIN || LOCK_CYCLES > LOCK_MAX) begin : g_bad_lock
        $error("debug_pll: LOCK_CYCLES out of range");
    end
    if (CLKIN_FREQ < 10.0 || CLKIN_FREQ > 500.0) begin : g_bad_freq
        $error("debug_pll: CLKIN_FREQ out of range");
    end
    if (INTERNAL_FB != FB_CLKOUTF || EXTERNAL_FB != FB_DISABLE) begin : g_bad_fb
        $error("debug_pll: unsupported feedback configuration");
    end

    pll_lock_detect #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_detect (
        .clk_i (clkin1_p),
        .rst_ni(rst_n),
        .clkn_i(clkin1_n),
        .lock_o(lock)
    );

    if (CLKOUT0_DIV == 1) begin : g_pass
        // Enable re-timed on the falling edge so it only changes while the reference is low.
        logic lock_latch_q;
        always_ff @(negedge clkin1_p or negedge rst_n) begin
            if (!rst_n) lock_latch_q <= 1'b0;
            else        lock_latch_q <= lock;
        end
        assign clkout0 = clkin1_p & lock_latch_q;
    end else begin : g_div
        localparam int DIV_W = clog2(CLKOUT0_DIV);
        localparam int HALF  = (CLKOUT0_DIV + 1) / 2;

        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             gate_q, gate_d;
        logic             clk_q, clk_d;

        // Gate opens only at a wrap, so the first visible high phase is full width.
        always_comb begin
            cnt_d  = (cnt_q == DIV_W'(CLKOUT0_DIV - 1)) ? '0 : cnt_q + DIV_W'(1);
            gate_d = gate_q | (lock & (cnt_q == '0));
            clk_d  = gate_d & (cnt_q < DIV_W'(HALF));
        end

        always_ff @(posedge clkin1_p or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                gate_q <= 1'b0;
                clk_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                gate_q <= gate_d;
                clk_q  <= clk_d;
            end
        end

        assign clkout0 = clk_q;
    end
endmodule

// File: tb/tb_debug_pll.sv
// Bench for debug_pll: three configurations share one reference and are
// compared each half-cycle against an edge-count model of lock and clkout0.
module tb_debug_pll;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int NDUT = 3;
    int DIVS [NDUT] = '{1, 4, 3};
    int LCKS [NDUT] = '{1024, 16, 16};
    int HIW  [NDUT] = '{0, 20, 20};
    int LOW  [NDUT] = '{0, 20, 10};

    logic             clkin1_p, clkin1_n, rst_n;
    logic [NDUT-1:0]  clk_o, lock_o;

    int  checks = 0;
    int  errors = 0;
    int  k;
    bit  prev_n;
    int  streak    [NDUT];
    int  lock_edge [NDUT];
    int  rise_edge [NDUT];
    bit  lk_prev   [NDUT];
    int  fell;
    bit  mon_en;
    longint last_t [NDUT];

    debug_pll #(.CLKOUT0_DIV(1), .LOCK_CYCLES(1024)) u_dut_a (
        .clkin1_p(clkin1_p), .rst_n(rst_n), .clkin1_n(clkin1_n),
        .clkout0(clk_o[0]), .lock(lock_o[0]));
    debug_pll #(.CLKOUT0_DIV(4), .LOCK_CYCLES(16)) u_dut_b (
        .clkin1_p(clkin1_p), .rst_n(rst_n), .clkin1_n(clkin1_n),
        .clkout0(clk_o[1]), .lock(lock_o[1]));
    debug_pll #(.CLKOUT0_DIV(3), .LOCK_CYCLES(16)) u_dut_c (
        .clkin1_p(clkin1_p), .rst_n(rst_n), .clkin1_n(clkin1_n),
        .clkout0(clk_o[2]), .lock(lock_o[2]));

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        prev_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            streak[i]    = 0;
            lock_edge[i] = -1;
            rise_edge[i] = -1;
            lk_prev[i]   = 1'b0;
        end
    endtask

    // Lock rises on the edge that completes LOCK_CYCLES consecutive good
    // evaluations; each edge evaluates the complement sampled one edge earlier.
    task automatic model_edge(input bit bad);
        k++;
        for (int i = 0; i < NDUT; i++) begin
            if (lock_edge[i] < 0) begin
                streak[i] = prev_n ? 0 : streak[i] + 1;
                if (streak[i] >= LCKS[i]) lock_edge[i] = k;
            end
        end
        prev_n = bad;
    endtask

    function automatic bit exp_clk(input int i, input bit hi);
        int g;
        if (lock_edge[i] < 0) return 1'b0;
        if (DIVS[i] == 1) return hi && (k > lock_edge[i]);
        g = lock_edge[i] + 1;
        while ((g - 1) % DIVS[i] != 0) g++;
        return (k >= g) && (((k - 1) % DIVS[i]) < (DIVS[i] + 1) / 2);
    endfunction

    task automatic check_all(input bit hi);
        for (int i = 0; i < NDUT; i++) begin
            if (hi) begin
                chk($sformatf("lock%0d_e%0d", i, k), lock_o[i], lock_edge[i] >= 0);
                if (lk_prev[i] && !lock_o[i]) fell++;
                if (lock_o[i] && !lk_prev[i] && rise_edge[i] < 0) rise_edge[i] = k;
                lk_prev[i] = lock_o[i];
            end
            chk($sformatf("clk%0d_%s_e%0d", i, hi ? "hi" : "lo", k), clk_o[i], exp_clk(i, hi));
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst_lock%0d", i), lock_o[i], 0);
            chk($sformatf("rst_clk%0d", i), clk_o[i], 0);
        end
    endtask

    // One reference period; optional 3 ns reset pulse inside the high phase.
    task automatic tick(input bit bad, input bit pulse);
        #1;
        clkin1_n = bad;
        clkin1_p = 1'b1;
        if (rst_n) model_edge(bad);
        #0.5;
        check_all(1'b1);
        if (pulse) begin
            rst_n = 1'b0;
            #1.5;
            check_reset();
            #1.5;
            rst_n = 1'b1;
            model_reset();
            #0.5;
        end else begin
            #3.5;
        end
        clkin1_p = 1'b0;
        clkin1_n = 1'b1;
        #1;
        check_all(1'b0);
        #4;
    endtask

    task automatic monitor_on();
        for (int i = 0; i < NDUT; i++) last_t[i] = -1;
        mon_en = 1'b1;
    endtask

    always @(clk_o[1]) begin
        if (mon_en) begin
            if (last_t[1] >= 0)
                chk(clk_o[1] ? "b_low_w" : "b_high_w", longint'($time) - last_t[1],
                    clk_o[1] ? LOW[1] : HIW[1]);
            last_t[1] = longint'($time);
        end
    end

    always @(clk_o[2]) begin
        if (mon_en) begin
            if (last_t[2] >= 0)
                chk(clk_o[2] ? "c_low_w" : "c_high_w", longint'($time) - last_t[2],
                    clk_o[2] ? LOW[2] : HIW[2]);
            last_t[2] = longint'($time);
        end
    end

    initial begin
        rst_n    = 1'b0;
        clkin1_p = 1'b0;
        clkin1_n = 1'b1;
        mon_en   = 1'b0;
        fell     = 0;
        model_reset();
        for (int i = 0; i < NDUT; i++) last_t[i] = -1;

        repeat (10) tick(1'b0, 1'b0);
        check_reset();
        rst_n = 1'b1;
        monitor_on();

        repeat (1030) tick(1'b0, 1'b0);
        chk("a_lock_edge", rise_edge[0], 1024);
        chk("b_lock_edge", rise_edge[1], 16);
        chk("c_lock_edge", rise_edge[2], 16);

        mon_en = 1'b0;
        tick(1'b0, 1'b1);
        for (int e = 1; e <= 50; e++) tick((e == 10) || (e == 40), 1'b0);
        chk("b_glitch_lock_edge", rise_edge[1], 27);
        chk("c_glitch_lock_edge", rise_edge[2], 27);
        chk("b_lock_after_glitch", lock_o[1], 1);
        chk("a_not_locked", lock_o[0], 0);

        repeat (600) tick($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);

        tick(1'b0, 1'b1);
        monitor_on();
        repeat (5000) tick(1'b0, 1'b0);
        chk("a_lock_50us", lock_o[0], 1);
        chk("a_final_lock_edge", rise_edge[0], 1024);
        chk("lock_never_fell", fell, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
